// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-access path and the SRAM access arbiter:
// data-port command encodings, arbiter state enumeration and a command decode helper.
package cpu_mem_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    WR_REC = 3'd4
  } arb_state_t;

  // 2'b11 is reserved and behaves exactly like idle.
  function automatic logic mem_active(input logic [1:0] ctrl);
    return (ctrl == MEM_READ) || (ctrl == MEM_WRITE);
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state timer: loads WAIT_CYCLES when an access starts and flags the final
// strobe cycle once the count has run down to zero.
module sram_wait_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic last_cycle
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(WAIT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = LOAD;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_cycle = (count_q == '0);

endmodule

// File: rtl/sram_access_arbiter.sv
// Multiplexes the core's fetch and data ports onto one asynchronous SRAM via a
// wait-state FSM; data wins over fetch. Define ACCESS_COUNT_EN to add access/stall counters.
module sram_access_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_valid,
  input  logic [1:0]        mem_ctrl,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              cpu_stall,
`ifdef ACCESS_COUNT_EN
  output logic [31:0]       if_count,
  output logic [31:0]       mem_count,
  output logic [31:0]       stall_count,
`endif
  output arb_state_t        dbg_state,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  // Handshake: if_req / active mem_ctrl are levels held by the core until the matching
  // one-cycle if_valid / mem_done pulse; a request is only accepted in IDLE outside the
  // pulse cycle, so a request still held during its own completion is never re-issued.

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_done_q, mem_done_d;
  logic              timer_start;
  logic              last_cycle;
  logic              bubble;

  sram_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .start     (timer_start),
    .last_cycle(last_cycle)
  );

  assign bubble = if_valid_q | mem_done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_done_d  = 1'b0;
    timer_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bubble) begin
          if (mem_ctrl == MEM_READ) begin
            state_d     = MEM_RD;
            addr_d      = mem_addr;
            timer_start = 1'b1;
          end else if (mem_ctrl == MEM_WRITE) begin
            state_d     = MEM_WR;
            addr_d      = mem_addr;
            wdata_d     = mem_wdata;
            timer_start = 1'b1;
          end else if (if_req) begin
            state_d     = IF_RD;
            addr_d      = if_addr;
            timer_start = 1'b1;
          end
        end
      end
      IF_RD: begin
        if (last_cycle) begin
          if_data_d  = sram_dq_in;
          if_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      MEM_RD: begin
        if (last_cycle) begin
          mem_rdata_d = sram_dq_in;
          mem_done_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      MEM_WR: begin
        if (last_cycle) begin
          state_d = WR_REC;
        end
      end
      WR_REC: begin
        mem_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // Strobes decode straight from the state register so a sampled reset releases them at once.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state_q)
      IF_RD, MEM_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      MEM_WR: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      WR_REC: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign if_data     = if_data_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_valid    = if_valid_q;
  assign mem_done    = mem_done_q;
  assign dbg_state   = state_q;
  assign cpu_stall   = (if_req & ~if_valid_q) | (mem_active(mem_ctrl) & ~mem_done_q);

`ifdef ACCESS_COUNT_EN
  logic [31:0] if_count_q, mem_count_q, stall_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      if_count_q    <= '0;
      mem_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (if_valid_q) if_count_q <= if_count_q + 32'd1;
      if (mem_done_q) mem_count_q <= mem_count_q + 32'd1;
      if (cpu_stall) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign if_count    = if_count_q;
  assign mem_count   = mem_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: an async SRAM model, a CPU-side driver that predicts
// each completion (data, cycle) into a queue, and a monitor that checks pulses and strobes.
module tb_sram_access_arbiter;
  import cpu_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 1;
  localparam int EW = 1 + DW + 32;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int   cyc = 0;
  logic rst_s = 1'b1;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
  end

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_data;
  logic          if_valid;
  logic [1:0]    mem_ctrl = 2'b00;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          cpu_stall;
  arb_state_t    dbg_state;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_in;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef ACCESS_COUNT_EN
  logic [31:0]   if_count, mem_count, stall_count;
`endif

  sram_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_data    (if_data),
    .if_valid   (if_valid),
    .mem_ctrl   (mem_ctrl),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .cpu_stall  (cpu_stall),
`ifdef ACCESS_COUNT_EN
    .if_count   (if_count),
    .mem_count  (mem_count),
    .stall_count(stall_count),
`endif
    .dbg_state  (dbg_state),
    .sram_addr  (sram_addr),
    .sram_dq_in (sram_dq_in),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  // asynchronous SRAM device: combinational read, write captured on the rising we_n
  logic [DW-1:0] sram_arr [0:65535];
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_arr[sram_addr] : 16'hDEAD;
  always @(posedge sram_we_n) begin
    if (sram_ce_n === 1'b0 && sram_dq_oe === 1'b1) sram_arr[sram_addr] <= sram_dq_out;
  end

  // reference model state and scoreboard
  logic [DW-1:0] shadow [0:65535];
  logic [DW-1:0] last_rd = '0;
  logic [EW-1:0] exp_q[$];
  int exp_if_done = 0;
  int exp_mem_done = 0;
  int n_if = 0, n_mem = 0, stall_acc = 0;
  int checks = 0, failures = 0;
  int oe_run = 0, we_run = 0;

  function automatic bit is_act(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return 16'h0200 + AW'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_pulse(input bit is_mem, input logic [DW-1:0] d);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pulse: kind=%0d data=%h at cycle %0d, expected no pulse", is_mem, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e[EW-1] !== is_mem || e[EW-2:32] !== d || e[31:0] !== 32'(cyc)) begin
        failures++;
        $display("FAIL completion: got kind=%0d data=%h cycle=%0d, expected kind=%0d data=%h cycle=%0d",
                 is_mem, d, cyc, e[EW-1], e[EW-2:32], e[31:0]);
      end
    end
  endtask

  // monitor: sampled on the falling edge, away from the DUT's active edge
  always @(negedge clock) begin
    logic exp_stall;
    exp_stall = (if_req && cyc < exp_if_done) || (is_act(mem_ctrl) && cyc < exp_mem_done);
    if (mem_done) check_pulse(1'b1, mem_rdata);
    if (if_valid) check_pulse(1'b0, if_data);
    if (rst_s || (!reset && !if_req && !is_act(mem_ctrl)))
      chk("strobes_idle", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
    if (reset) begin
      stall_acc = 0;
      oe_run    = 0;
      we_run    = 0;
    end else begin
      chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, exp_stall});
      if (exp_stall) stall_acc++;
      if (!sram_oe_n) begin
        oe_run++;
        chk("read_dq_oe_we", {30'd0, sram_dq_oe, sram_we_n}, 32'h1);
      end else if (oe_run != 0) begin
        chk("oe_low_cycles", oe_run, W + 1);
        oe_run = 0;
      end
      if (!sram_we_n) begin
        we_run++;
      end else if (we_run != 0) begin
        chk("we_low_cycles", we_run, W + 1);
        chk("wr_rec_dq_oe", {31'd0, sram_dq_oe}, 32'h1);
        we_run = 0;
      end
    end
  end

  // driver: called aligned just after a rising edge; returns aligned in the cycle after
  // the last completion with all requests dropped
  task automatic do_txn(input bit do_if, input logic [AW-1:0] ia, input logic [1:0] mc,
                        input logic [AW-1:0] ma, input logic [DW-1:0] wd);
    int  t0, nxt, last;
    bit  act;
    t0 = cyc; act = is_act(mc); nxt = t0; last = t0;
    if (act) begin
      if (mc == MEM_WRITE) begin
        shadow[ma]   = wd;
        exp_mem_done = t0 + W + 3;
      end else begin
        last_rd      = shadow[ma];
        exp_mem_done = t0 + W + 2;
      end
      exp_q.push_back({1'b1, last_rd, 32'(exp_mem_done)});
      n_mem++;
      nxt  = exp_mem_done + 1;
      last = exp_mem_done;
    end
    if (do_if) begin
      exp_if_done = nxt + W + 2;
      exp_q.push_back({1'b0, shadow[ia], 32'(exp_if_done)});
      n_if++;
      last = exp_if_done;
    end
    if_req = do_if; if_addr = ia; mem_ctrl = mc; mem_addr = ma; mem_wdata = wd;
    while (cyc <= last) begin
      @(posedge clock); #1;
      if (act && cyc > exp_mem_done) mem_ctrl = MEM_IDLE;
      if (cyc > exp_if_done) if_req = 1'b0;
    end
    mem_ctrl = MEM_IDLE;
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] mc);
    for (int i = 0; i < n; i++) begin
      if_req = 1'b0; mem_ctrl = mc;
      @(posedge clock); #1;
    end
    mem_ctrl = MEM_IDLE;
  endtask

  initial begin
    int kind;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] wd;
    for (int i = 0; i < 65536; i++) begin
      wd = DW'($urandom);
      sram_arr[i] = wd;
      shadow[i]   = wd;
    end
    sram_arr[16'h0040] = 16'hBEEF;
    shadow[16'h0040]   = 16'hBEEF;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_if_data", 32'(if_data), 32'h0);
    chk("reset_mem_rdata", 32'(mem_rdata), 32'h0);
    chk("reset_pulses", {30'd0, if_valid, mem_done}, 32'h0);
    chk("reset_sram_addr", 32'(sram_addr), 32'h0);
    chk("reset_dq_out", 32'(sram_dq_out), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));

    // reset held 3 cycles in the middle of a fetch: abandoned, no pulse
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 16'h0040; exp_if_done = 32'h7fff_ffff;
    @(posedge clock); #1;
    reset = 1'b1; if_req = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("abort_if_data", 32'(if_data), 32'h0);
    chk("abort_mem_rdata", 32'(mem_rdata), 32'h0);
    n_if = 0; n_mem = 0;

    do_txn(1'b1, 16'h0040, MEM_IDLE, 16'h0000, 16'h0000);
    do_txn(1'b1, 16'h0100, MEM_WRITE, 16'h0100, 16'h1234);
    do_txn(1'b0, 16'h0000, MEM_WRITE, 16'hFFFF, 16'hA5A5);
    do_txn(1'b0, 16'h0000, MEM_READ, 16'hFFFF, 16'h0000);
    idle_cycles(5, 2'b11);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      a1 = rand_addr();
      a2 = rand_addr();
      wd = DW'($urandom);
      case (kind)
        0: do_txn(1'b1, a1, MEM_IDLE, a2, wd);
        1: do_txn(1'b0, a1, MEM_READ, a2, wd);
        2: do_txn(1'b0, a1, MEM_WRITE, a2, wd);
        3: do_txn(1'b1, a1, MEM_WRITE, a2, wd);
        4: do_txn(1'b1, a1, MEM_READ, a2, wd);
        default: do_txn(1'b1, a1, 2'b11, a2, wd);
      endcase
      if ($urandom_range(0, 3) == 0)
        idle_cycles($urandom_range(1, 3), ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
    end

    idle_cycles(2, MEM_IDLE);
    @(negedge clock);
`ifdef ACCESS_COUNT_EN
    chk("if_count", if_count, n_if);
    chk("mem_count", mem_count, n_mem);
    chk("stall_count", stall_count, stall_acc);
`endif
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
